// File: rtl/conv_bias_sched_pkg.sv
// conv_bias_sched_pkg: shared FSM encoding and pipeline latency constants for the bias-stage sequencer
package conv_bias_sched_pkg;
  localparam int DEF_FIFO_RD_LATENCY = 1;
  localparam int DEF_ADD_LATENCY = 2;
  localparam int PIPE_LAT = DEF_FIFO_RD_LATENCY + DEF_ADD_LATENCY;
  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/conv_bias_sched_valid_delay_line.sv
// conv_bias_sched_valid_delay_line: fixed-depth shift register carrying {valid, last} alongside the datapath
module conv_bias_sched_valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  // each stage takes the previous one; stage 0 takes the input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/conv_bias_sched.sv
// conv_bias_sched: group/row/pixel sequencer for the bias stage with adder-aligned valid regeneration
module conv_bias_sched
  import conv_bias_sched_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_BIAS_ADDR = 7,
  parameter int FIFO_RD_LATENCY = DEF_FIFO_RD_LATENCY,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Start,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]    S_Count_Fifo,
  input  logic                             fifo_ready,
  input  logic                             M_Ready,
  output logic                             Next_Reg,
  output logic                             rd_en_fifo,
  output logic                             bias_rd_en,
  output logic [WIDTH_BIAS_ADDR-1:0]       bias_addr,
  output logic                             M_Valid,
  output logic                             M_Last,
  output logic                             busy,
  output logic                             Done
);
  localparam int LAT = FIFO_RD_LATENCY + ADD_LATENCY;
  localparam int SH = $clog2(CHANNEL_OUT_NUM);
  localparam int WD = $clog2(LAT + 1);
  localparam logic [WIDTH_FEATURE_SIZE-1:0] F1 = 1;
  localparam logic [WIDTH_CHANNEL_NUM_REG-1:0] C1 = 1;
  localparam logic [WD-1:0] D1 = 1;
  localparam logic [WD-1:0] DLAST = WD'(LAT - 1);
  state_t state, next;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_q, grp_cnt, grp_num;
  logic [WIDTH_FEATURE_SIZE-1:0] rows_q, cols_q, row_cnt, col_cnt;
  logic [WD-1:0] drain_cnt;
  logic accept, empty, last_col, last_row, last_grp, last_drain, last_pix;
  logic [1:0] dly_q;
  assign grp_num = (ch_q >> SH) == '0 ? C1 : ch_q >> SH;
  assign accept = state == S_IDLE && Start;
  assign empty = Row_Num_Out_REG == '0 || S_Count_Fifo == '0;
  assign last_col = col_cnt == cols_q - F1;
  assign last_row = row_cnt == rows_q - F1;
  assign last_grp = grp_cnt == grp_num - C1;
  assign last_drain = drain_cnt == DLAST;
  assign last_pix = rd_en_fifo && last_col && last_row && last_grp;
  assign rd_en_fifo = state == S_READ;
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= next;
  end
  // next-state: group outer, row middle, pixel inner; drain before the bias word changes
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = Start ? (empty ? S_DONE : S_BIAS) : S_IDLE;
      S_BIAS:  next = S_WAIT;
      S_WAIT:  next = fifo_ready && M_Ready ? S_READ : S_WAIT;
      S_READ:  next = last_col ? (last_row ? S_DRAIN : S_WAIT) : S_READ;
      S_DRAIN: next = last_drain ? (last_grp ? S_DONE : S_BIAS) : S_DRAIN;
      default: next = S_IDLE;
    endcase
  end
  // config latch on accepted start and the pixel/row/group/drain counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      grp_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      ch_q <= Channel_Out_Num_REG;
      rows_q <= Row_Num_Out_REG;
      cols_q <= S_Count_Fifo;
      grp_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (rd_en_fifo) col_cnt <= last_col ? '0 : col_cnt + F1;
      if (rd_en_fifo && last_col) row_cnt <= row_cnt + F1;
      if (state == S_DRAIN) drain_cnt <= last_drain ? '0 : drain_cnt + D1;
      if (state == S_DRAIN && last_drain) begin
        row_cnt <= '0;
        grp_cnt <= grp_cnt + C1;
      end
    end
  end
  // registered control strobes: FIFO clear, busy flag, bias fetch, completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Next_Reg <= 1'b0;
      busy <= 1'b0;
      bias_rd_en <= 1'b0;
      bias_addr <= '0;
      Done <= 1'b0;
    end else begin
      Next_Reg <= accept;
      busy <= accept || (busy && state != S_DONE);
      bias_rd_en <= state == S_BIAS;
      if (state == S_BIAS) bias_addr <= grp_cnt[WIDTH_BIAS_ADDR-1:0];
      Done <= state == S_DONE;
    end
  end
  conv_bias_sched_valid_delay_line #(.DEPTH(LAT), .W(2)) u_dly (
    .clk(clk),
    .rst(rst),
    .d({rd_en_fifo, last_pix}),
    .q(dly_q)
  );
  assign {M_Valid, M_Last} = dly_q;
endmodule

// File: doc/conv_bias_sched.md
# conv_bias_sched

Sequencer for the convolution bias stage. It walks the output feature map by channel group and row, and fetches the per-group bias word from the bias RAM. It issues row-length read bursts to the bias-stage FIFO whenever that FIFO holds a full row and the downstream stage can accept one. It also regenerates an output-valid strobe aligned with the pipelined 32-bit bias adders. It sits between the layer control registers and the bias datapath (FIFO plus `CHANNEL_OUT_NUM` adders per picture).

## Interface
- `CHANNEL_OUT_NUM`, 8: channels per group; the group count is `Channel_Out_Num_REG / CHANNEL_OUT_NUM`.
- `WIDTH_FEATURE_SIZE`, 12: width of the row and column counts.
- `WIDTH_CHANNEL_NUM_REG`, 10: width of the channel-count register.
- `WIDTH_BIAS_ADDR`, 7: bias RAM address width.
- `FIFO_RD_LATENCY`, 1: cycles from `rd_en_fifo` to valid FIFO `dout`.
- `ADD_LATENCY`, 2: cycles through the bias adder.

Ports:
- `clk`  in  1  the single clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  one-cycle layer start; ignored while `busy`.
- `Channel_Out_Num_REG`  in  `WIDTH_CHANNEL_NUM_REG`  output channel count; latched on `Start`.
- `Row_Num_Out_REG`  in  `WIDTH_FEATURE_SIZE`  output rows; latched on `Start`.
- `S_Count_Fifo`  in  `WIDTH_FEATURE_SIZE`  pixels per row; latched on `Start`.
- `fifo_ready`  in  1  FIFO holds at least one full row.
- `M_Ready`  in  1  downstream can take one full row.
- `Next_Reg`  out  1  one-cycle FIFO clear, issued on accepted `Start`.
- `rd_en_fifo`  out  1  FIFO read strobe.
- `bias_rd_en`  out  1  bias RAM read strobe.
- `bias_addr`  out  `WIDTH_BIAS_ADDR`  bias RAM address (the group index).
- `M_Valid`  out  1  `M_Data` valid, aligned with the adder output.
- `M_Last`  out  1  qualifies the last pixel of the layer.
- `busy`  out  1  the sequencer is running.
- `Done`  out  1  one-cycle pulse when the layer has completed.

## Operation
- Reset value of every output is 0. All counters reset to 0 and the FSM resets to IDLE.
- Group count `G = Channel_Out_Num_REG >> log2(CHANNEL_OUT_NUM)`. If `G` is 0 it is forced to 1.
- Loop order: group (outer), then row, then pixel (inner).
- **IDLE**: waits for `Start`. On `Start`:
  - latch the three config inputs;
  - pulse `Next_Reg`;
  - set `busy`;
  - go to BIAS.
- **Empty layer**: if `Row_Num_Out_REG` is 0 or `S_Count_Fifo` is 0, go from IDLE straight to DONE. No reads are issued.
- **BIAS**: assert `bias_rd_en` for one cycle with `bias_addr = group_cnt`, then go to WAIT. The RAM has 1-cycle latency, so the bias word is stable before any read of that group.
- **WAIT**: when `fifo_ready && M_Ready` is high on the same cycle, go to READ. Both inputs are sampled only in this state.
- **READ**: hold `rd_en_fifo` high for exactly `S_Count_Fifo` consecutive cycles; `col_cnt` counts 0 to N-1.
  - On the last pixel, advance `row_cnt`.
  - If rows remain, go to WAIT.
  - Otherwise go to DRAIN.
- **DRAIN**: wait `FIFO_RD_LATENCY + ADD_LATENCY` cycles so the adder pipeline empties before the bias word changes.
  - Then clear `row_cnt` and increment `group_cnt`.
  - Go to BIAS if groups remain, otherwise to DONE.
- **DONE**: pulse `Done`, clear `busy`, go to IDLE.
- `M_Valid` is `rd_en_fifo` delayed by `FIFO_RD_LATENCY + ADD_LATENCY` through a shift register.
- `M_Last` is delayed by the same amount and marks the final pixel of the final row of the final group.
- `Start` while `busy` is ignored and does not disturb the latched config.
- Reset mid-burst returns everything to the reset state immediately. The FIFO content is then stale; a later `Start` clears it with `Next_Reg`.

## Timing
- `Start` accepted at cycle t:
  - `Next_Reg` and `busy` are high at t+1;
  - `bias_rd_en` is high at t+2.
- WAIT condition true at cycle w: first `rd_en_fifo` at w+1.
- Per row: `S_Count_Fifo` read cycles plus 1 WAIT cycle minimum.
- `M_Valid` follows `rd_en_fifo` by exactly `FIFO_RD_LATENCY + ADD_LATENCY` cycles (3 at defaults).
- `Done` is asserted on the cycle after the last `M_Valid` or later, never earlier.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, BIAS, WAIT, READ, DRAIN, DONE);
  - `PIPE_LAT = FIFO_RD_LATENCY + ADD_LATENCY`.
- Natural sub-module: `valid_delay_line`, a parameterised shift register of depth `PIPE_LAT` carrying {valid, last}.

## Test plan
- `Channel_Out_Num_REG=16`, `Row_Num_Out_REG=2`, `S_Count_Fifo=4`, `fifo_ready` and `M_Ready` held high:
  - `bias_addr` reads 0, then 1;
  - 16 `rd_en_fifo` cycles in 4 bursts of 4;
  - 16 `M_Valid` cycles, each 3 cycles after its read;
  - a single `M_Last`, then `Done`.
- `M_Ready` low for 10 cycles while in WAIT → no `rd_en_fifo` during that window; the burst starts 1 cycle after `M_Ready` rises.
- `Channel_Out_Num_REG=4` → treated as 1 group; only `bias_addr=0` is read.
- `Row_Num_Out_REG=0` → `Done` 2 cycles after `Start`; no `rd_en_fifo` and no `bias_rd_en`.
- `Start` pulsed mid-layer with different config → output sequence identical to the undisturbed run.
- `rst` asserted during READ → all outputs are 0 in the same cycle (async). A new `Start` then gives a fresh `Next_Reg` and the full sequence from group 0.
